// File: rtl/hwpe_stream_tcdm_reorder_dynamic_if.sv
// -----------------------------------------------------------------------------
// hwpe_stream_intf_tcdm
// TCDM request/response bundle shared by HWPE streamers and the cluster
// interconnect.
//   master : drives req/add/wen/be/data, receives gnt/r_data/r_valid
//   slave  : receives req/add/wen/be/data, drives gnt/r_data/r_valid
// wen = 1 marks a read, wen = 0 a write.
// -----------------------------------------------------------------------------
interface hwpe_stream_intf_tcdm #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32,
  parameter int unsigned BW = DW / 8
) ();

  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [BW-1:0] be;
  logic [DW-1:0] data;
  logic [DW-1:0] r_data;
  logic          r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/hwpe_stream_tcdm_reorder_dynamic.sv
// -----------------------------------------------------------------------------
// hwpe_stream_tcdm_reorder_dynamic
// Rotating permutation between NB_CHAN HWPE TCDM master ports and NB_CHAN
// interconnect ports. out[j] carries in[(j + off) mod NB_CHAN]; the offset
// advances by itself so that the downstream banks see an even load. Each
// output keeps a LATENCY-deep record of which input was granted, so that
// responses still go back to their issuer after the mapping has moved on.
//
// Ports
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear of offset, counter, tracking and error
//   enable_i      : rotation enable (offset frozen while low)
//   in[]          : upstream requesters (slave side)
//   out[]         : downstream TCDM ports (master side)
//   order_o       : current offset, debug only
//   err_o         : sticky, a response arrived with no tracked grant
//
// Build option
//   HWPE_TCDM_REORDER_RANDOM_EN : offset taken from a 16-bit Fibonacci LFSR
//   (taps 16,14,13,11, seed 16'hACE1) instead of incrementing. Requires a
//   power-of-two NB_CHAN.
// -----------------------------------------------------------------------------
module hwpe_stream_tcdm_reorder_dynamic #(
  parameter int unsigned NB_CHAN       = 4,
  parameter int unsigned DW            = 32,
  parameter int unsigned AW            = 32,
  parameter int unsigned BW            = DW / 8,
  parameter int unsigned LATENCY       = 1,
  parameter int unsigned ROTATE_PERIOD = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       enable_i,
  hwpe_stream_intf_tcdm.slave        in  [NB_CHAN],
  hwpe_stream_intf_tcdm.master       out [NB_CHAN],
  output logic [$clog2(NB_CHAN)-1:0] order_o,
  output logic                       err_o
);

  localparam int unsigned OW = $clog2(NB_CHAN);
  localparam int unsigned CW = (ROTATE_PERIOD > 1) ? $clog2(ROTATE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ROTATE_PERIOD - 1);
  localparam logic [OW-1:0] OFF_MAX = OW'(NB_CHAN - 1);

  typedef logic [OW-1:0] idx_t;

  // (j + off) mod NB_CHAN by compare-and-subtract; the sum never exceeds
  // 2*NB_CHAN-2, so one subtraction is enough and non-power-of-2 works.
  function automatic idx_t wrap_add(input int unsigned j, input idx_t off);
    logic [OW:0] sum;
    sum = (OW+1)'(j) + {1'b0, off};
    if (sum >= (OW+1)'(NB_CHAN)) sum = sum - (OW+1)'(NB_CHAN);
    return sum[OW-1:0];
  endfunction

  // Flat copies of the interface arrays, so they can be indexed by a signal.
  logic [NB_CHAN-1:0] in_req, in_wen, in_gnt, in_rvalid;
  logic [AW-1:0]      in_add   [NB_CHAN];
  logic [BW-1:0]      in_be    [NB_CHAN];
  logic [DW-1:0]      in_data  [NB_CHAN];
  logic [DW-1:0]      in_rdata [NB_CHAN];
  logic [NB_CHAN-1:0] out_req, out_wen, out_gnt, out_rvalid;
  logic [AW-1:0]      out_add   [NB_CHAN];
  logic [BW-1:0]      out_be    [NB_CHAN];
  logic [DW-1:0]      out_data  [NB_CHAN];
  logic [DW-1:0]      out_rdata [NB_CHAN];

  for (genvar g = 0; g < NB_CHAN; g++) begin : g_flat
    assign in_req[g]      = in[g].req;
    assign in_wen[g]      = in[g].wen;
    assign in_add[g]      = in[g].add;
    assign in_be[g]       = in[g].be;
    assign in_data[g]     = in[g].data;
    assign in[g].gnt      = in_gnt[g];
    assign in[g].r_valid  = in_rvalid[g];
    assign in[g].r_data   = in_rdata[g];
    assign out[g].req     = out_req[g];
    assign out[g].wen     = out_wen[g];
    assign out[g].add     = out_add[g];
    assign out[g].be      = out_be[g];
    assign out[g].data    = out_data[g];
    assign out_gnt[g]     = out[g].gnt;
    assign out_rvalid[g]  = out[g].r_valid;
    assign out_rdata[g]   = out[g].r_data;
  end

  idx_t          off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  idx_t          src [NB_CHAN];
  logic          stall, rotate, orphan;

  // Tracking pipeline per output: stage 0 is the newest grant.
  logic [LATENCY-1:0] trk_v_q   [NB_CHAN];
  idx_t               trk_src_q [NB_CHAN][LATENCY];

`ifdef HWPE_TCDM_REORDER_RANDOM_EN
  if (NB_CHAN != (1 << OW)) begin : g_pow2_check
    $error("NB_CHAN must be a power of two with HWPE_TCDM_REORDER_RANDOM_EN");
  end
  logic [15:0] lfsr_q, lfsr_d, lfsr_step;
  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif

  // Request path: purely combinational, the mapping is a bijection.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int j = 0; j < NB_CHAN; j++) begin
      src[j]      = wrap_add(j, off_q);
      out_req[j]  = in_req[src[j]];
      out_wen[j]  = in_wen[src[j]];
      out_add[j]  = in_add[src[j]];
      out_be[j]   = in_be[src[j]];
      out_data[j] = in_data[src[j]];
    end
  end

  always_comb begin
    in_gnt = '0;
    for (int j = 0; j < NB_CHAN; j++) in_gnt[src[j]] = out_gnt[j];
  end

  // Response path: the tail entry names the input that owns this response.
  always_comb begin
    in_rvalid = '0;
    orphan    = 1'b0;
    for (int i = 0; i < NB_CHAN; i++) in_rdata[i] = '0;
    for (int j = 0; j < NB_CHAN; j++) begin
      if (out_rvalid[j]) begin
        if (trk_v_q[j][LATENCY-1]) begin
          in_rvalid[trk_src_q[j][LATENCY-1]] = 1'b1;
          in_rdata[trk_src_q[j][LATENCY-1]]  = out_rdata[j];
        end else begin
          orphan = 1'b1;
        end
      end
    end
  end

  // A stalled request must keep seeing the same output, so it blocks rotation.
  assign stall  = |(out_req & ~out_gnt);
  assign rotate = enable_i && (cnt_q == CNT_MAX) && !stall;

  always_comb begin
    off_d = off_q;
    cnt_d = cnt_q;
    err_d = err_q | orphan;
`ifdef HWPE_TCDM_REORDER_RANDOM_EN
    lfsr_d = lfsr_q;
`endif
    if (clear_i) begin
      off_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
`ifdef HWPE_TCDM_REORDER_RANDOM_EN
      lfsr_d = 16'hACE1;
`endif
    end else if (rotate) begin
      cnt_d = '0;
`ifdef HWPE_TCDM_REORDER_RANDOM_EN
      lfsr_d = lfsr_step;
      off_d  = lfsr_step[OW-1:0];
`else
      off_d = (off_q == OFF_MAX) ? '0 : off_q + 1'b1;
`endif
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
`ifdef HWPE_TCDM_REORDER_RANDOM_EN
      lfsr_q <= 16'hACE1;
`endif
    end else begin
      off_q <= off_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
`ifdef HWPE_TCDM_REORDER_RANDOM_EN
      lfsr_q <= lfsr_d;
`endif
    end
  end

  // NOTE: the tracking array is control state, not a data memory, so it is reset; a stale valid would misroute a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NB_CHAN; j++) begin
        trk_v_q[j] <= '0;
        for (int k = 0; k < LATENCY; k++) trk_src_q[j][k] <= '0;
      end
    end else if (clear_i) begin
      for (int j = 0; j < NB_CHAN; j++) trk_v_q[j] <= '0;
    end else begin
      for (int j = 0; j < NB_CHAN; j++) begin
        trk_v_q[j][0]   <= out_req[j] & out_gnt[j];
        trk_src_q[j][0] <= src[j];
        for (int k = 1; k < LATENCY; k++) begin
          trk_v_q[j][k]   <= trk_v_q[j][k-1];
          trk_src_q[j][k] <= trk_src_q[j][k-1];
        end
      end
    end
  end

  assign order_o = off_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_reorder_dynamic.sv
// -----------------------------------------------------------------------------
// Bench for hwpe_stream_tcdm_reorder_dynamic.
// dut4: NB_CHAN=4, LATENCY=2, ROTATE_PERIOD=1, driven through a downstream
//       memory model; granted requests push their expected response into a
//       scoreboard that is popped when an input sees r_valid.
// dut3: NB_CHAN=3, LATENCY=1, ROTATE_PERIOD=3, offset sequence and mapping.
// -----------------------------------------------------------------------------
module tb_hwpe_stream_tcdm_reorder_dynamic;

  localparam int N4 = 4;
  localparam int L4 = 2;
  localparam int N3 = 3;
  localparam int P3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear4, enable4, clear3, enable3;
  logic [1:0] order4, order3;
  logic err4, err3;

  int checks   = 0;
  int failures = 0;

  // ---------------- dut4 plumbing ----------------
  hwpe_stream_intf_tcdm #(.DW(32), .AW(32)) in4  [N4] ();
  hwpe_stream_intf_tcdm #(.DW(32), .AW(32)) out4 [N4] ();

  logic [N4-1:0] i4_req, i4_wen, i4_gnt, i4_rv;
  logic [31:0]   i4_add [N4], i4_data [N4], i4_rd [N4];
  logic [3:0]    i4_be  [N4];
  logic [N4-1:0] o4_req, o4_wen, o4_gnt, o4_rv;
  logic [31:0]   o4_add [N4], o4_data [N4], o4_rd [N4];
  logic [3:0]    o4_be  [N4];

  for (genvar g = 0; g < N4; g++) begin : g_b4
    assign in4[g].req     = i4_req[g];
    assign in4[g].wen     = i4_wen[g];
    assign in4[g].add     = i4_add[g];
    assign in4[g].be      = i4_be[g];
    assign in4[g].data    = i4_data[g];
    assign i4_gnt[g]      = in4[g].gnt;
    assign i4_rv[g]       = in4[g].r_valid;
    assign i4_rd[g]       = in4[g].r_data;
    assign o4_req[g]      = out4[g].req;
    assign o4_wen[g]      = out4[g].wen;
    assign o4_add[g]      = out4[g].add;
    assign o4_be[g]       = out4[g].be;
    assign o4_data[g]     = out4[g].data;
    assign out4[g].gnt    = o4_gnt[g];
    assign out4[g].r_valid = o4_rv[g];
    assign out4[g].r_data = o4_rd[g];
  end

  hwpe_stream_tcdm_reorder_dynamic #(
    .NB_CHAN(N4), .DW(32), .AW(32), .LATENCY(L4), .ROTATE_PERIOD(1)
  ) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear4), .enable_i(enable4),
    .in(in4), .out(out4), .order_o(order4), .err_o(err4)
  );

  // ---------------- dut3 plumbing ----------------
  hwpe_stream_intf_tcdm #(.DW(32), .AW(32)) in3  [N3] ();
  hwpe_stream_intf_tcdm #(.DW(32), .AW(32)) out3 [N3] ();

  logic [N3-1:0] i3_req, i3_gnt, i3_rv, o3_req, o3_gnt;
  logic [31:0]   i3_add [N3], o3_add [N3];

  for (genvar g = 0; g < N3; g++) begin : g_b3
    assign in3[g].req      = i3_req[g];
    assign in3[g].wen      = 1'b1;
    assign in3[g].add      = i3_add[g];
    assign in3[g].be       = 4'hF;
    assign in3[g].data     = 32'h0;
    assign i3_gnt[g]       = in3[g].gnt;
    assign i3_rv[g]        = in3[g].r_valid;
    assign o3_req[g]       = out3[g].req;
    assign o3_add[g]       = out3[g].add;
    assign out3[g].gnt     = o3_gnt[g];
    assign out3[g].r_valid = 1'b0;
    assign out3[g].r_data  = 32'h0;
  end

  hwpe_stream_tcdm_reorder_dynamic #(
    .NB_CHAN(N3), .DW(32), .AW(32), .LATENCY(1), .ROTATE_PERIOD(P3)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear3), .enable_i(enable3),
    .in(in3), .out(out3), .order_o(order3), .err_o(err3)
  );

  // ---------------- reference model state for dut4 ----------------
  typedef struct {
    int          idx;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t          sb [$];
  int            exp_off = 0;
  bit            exp_err = 1'b0;
  int            cyc     = 0;
  logic [N4-1:0] inj_rv;
  logic [N4-1:0] pv [L4];
  logic [31:0]   pd [L4][N4];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h200) ? 32'hDEADBEEF : (a ^ 32'h1234_5678);
  endfunction

  // Output that carries input i under offset off.
  function automatic int map_out(input int i, input int off);
    return (i - off + N4) % N4;
  endfunction

  // One dut4 clock: check at the falling edge, advance the model, then drive
  // the downstream responder just after the rising edge.
  task automatic step();
    logic [N4-1:0] g;
    logic [31:0]   ga [N4];
    bit            stall;
    int            nxt_off;
    bit            nxt_err;
    int            i;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < N4; k++) begin
      if (i4_rv[k]) begin
        checks++;
        if (sb.size() == 0 || sb[0].due != cyc || sb[0].idx != k) begin
          failures++;
          $display("FAIL rsp_route in[%0d] cyc=%0d: r_valid=1, expected no response here", k, cyc);
        end else begin
          if (i4_rd[k] !== sb[0].data) begin
            failures++;
            $display("FAIL rsp_data in[%0d] cyc=%0d: got %h expected %h", k, cyc, i4_rd[k], sb[0].data);
          end
          void'(sb.pop_front());
        end
      end
    end
    checks++;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      failures++;
      $display("FAIL rsp_missing in[%0d] cyc=%0d: no r_valid, expected %h", sb[0].idx, cyc, sb[0].data);
      while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
    end
    checks++;
    if (order4 !== 2'(exp_off)) begin
      failures++;
      $display("FAIL order4 cyc=%0d: got %0d expected %0d", cyc, order4, exp_off);
    end
    checks++;
    if (err4 !== exp_err) begin
      failures++;
      $display("FAIL err4 cyc=%0d: got %b expected %b", cyc, err4, exp_err);
    end
    checks++;
    if ($countones(o4_rv & ~inj_rv) != $countones(i4_rv)) begin
      failures++;
      $display("FAIL rsp_collision cyc=%0d: out r_valid %b vs in r_valid %b", cyc, o4_rv, i4_rv);
    end
    stall = 1'b0;
    for (int j = 0; j < N4; j++) begin
      i = (j + exp_off) % N4;
      checks++;
      if ({o4_req[j], o4_wen[j], o4_add[j], o4_be[j], o4_data[j]} !==
          {i4_req[i], i4_wen[i], i4_add[i], i4_be[i], i4_data[i]}) begin
        failures++;
        $display("FAIL req_map out[%0d] cyc=%0d: req=%b add=%h, expected in[%0d] req=%b add=%h",
                 j, cyc, o4_req[j], o4_add[j], i, i4_req[i], i4_add[i]);
      end
      checks++;
      if (i4_gnt[i] !== o4_gnt[j]) begin
        failures++;
        $display("FAIL gnt_map in[%0d] cyc=%0d: got %b expected %b", i, cyc, i4_gnt[i], o4_gnt[j]);
      end
      g[j]  = i4_req[i] & o4_gnt[j];
      ga[j] = i4_add[i];
      if (i4_req[i] && !o4_gnt[j]) stall = 1'b1;
    end
    for (int k = 0; k < N4; k++)
      if (!clear4 && i4_req[k] && o4_gnt[map_out(k, exp_off)])
        sb.push_back('{k, mem_rd(i4_add[k]), cyc + L4});
    nxt_err = clear4 ? 1'b0 : (exp_err | (|inj_rv));
    nxt_off = clear4 ? 0 : ((enable4 && !stall) ? (exp_off + 1) % N4 : exp_off);
    @(posedge clk);
    #1;
    exp_off = nxt_off;
    exp_err = nxt_err;
    for (int s = L4 - 1; s > 0; s--) begin
      pv[s] = pv[s-1];
      for (int j = 0; j < N4; j++) pd[s][j] = pd[s-1][j];
    end
    pv[0] = g;
    for (int j = 0; j < N4; j++) pd[0][j] = mem_rd(ga[j]);
    inj_rv = '0;
    o4_rv  = pv[L4-1];
    for (int j = 0; j < N4; j++) o4_rd[j] = pv[L4-1][j] ? pd[L4-1][j] : 32'h0;
  endtask

  task automatic drain();
    i4_req = '0;
    repeat (L4 + 2) step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (order4 !== 2'd0) begin failures++; $display("FAIL reset_order4: got %0d expected 0", order4); end
    checks++;
    if (err4 !== 1'b0) begin failures++; $display("FAIL reset_err4: got %b expected 0", err4); end
    checks++;
    if (i4_rv !== '0) begin failures++; $display("FAIL reset_rvalid4: got %b expected 0", i4_rv); end
    checks++;
    if (order3 !== 2'd0 || err3 !== 1'b0) begin
      failures++; $display("FAIL reset_dut3: order=%0d err=%b expected 0/0", order3, err3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    enable4 = 1'b0;
    i4_req[2] = 1'b1; i4_wen[2] = 1'b0; i4_add[2] = 32'h100;
    i4_be[2] = 4'hA; i4_data[2] = 32'hCAFE_0002;
    o4_gnt = 4'b1011;
    #1;
    checks++;
    if ({o4_req[2], o4_wen[2], o4_add[2], o4_data[2]} !== {1'b1, 1'b0, 32'h100, 32'hCAFE_0002}) begin
      failures++; $display("FAIL pass_req out[2]: req=%b add=%h expected 1/00000100", o4_req[2], o4_add[2]);
    end
    checks++;
    if (i4_gnt[2] !== 1'b0) begin failures++; $display("FAIL pass_gnt_low in[2]: got %b expected 0", i4_gnt[2]); end
    repeat (3) step();
    o4_gnt = '1;
    #1;
    checks++;
    if (i4_gnt[2] !== 1'b1) begin failures++; $display("FAIL pass_gnt_high in[2]: got %b expected 1", i4_gnt[2]); end
    repeat (2) step();
    checks++;
    if (order4 !== 2'd0) begin failures++; $display("FAIL pass_order: got %0d expected 0", order4); end
    drain();
  endtask

  task automatic test_rotation();
    enable4 = 1'b1;
    o4_gnt  = '1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N4; i++) begin
        i4_req[i] = 1'b1; i4_wen[i] = 1'b1; i4_be[i] = 4'hF;
        i4_add[i] = {$urandom_range(255, 0), 24'h0} | 32'(i << 4) | 32'(k);
        i4_data[i] = $urandom;
      end
      #1;
      checks++;
      if (order4 !== 2'(k % N4)) begin
        failures++; $display("FAIL rot_order step %0d: got %0d expected %0d", k, order4, k % N4);
      end
      checks++;
      if (o4_add[0] !== i4_add[k % N4]) begin
        failures++; $display("FAIL rot_out0 step %0d: got %h expected in[%0d] %h", k, o4_add[0], k % N4, i4_add[k % N4]);
      end
      step();
    end
    drain();
  endtask

  task automatic test_stall();
    int frozen;
    enable4 = 1'b1;
    o4_gnt  = '0;
    i4_req[1] = 1'b1; i4_wen[1] = 1'b1; i4_add[1] = 32'h40;
    frozen = exp_off;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      checks++;
      if (order4 !== 2'(frozen)) begin
        failures++; $display("FAIL stall_order cycle %0d: got %0d expected %0d", k, order4, frozen);
      end
    end
    o4_gnt = '1;
    step();
    #1;
    checks++;
    if (order4 !== 2'((frozen + 1) % N4)) begin
      failures++; $display("FAIL stall_release: got %0d expected %0d", order4, (frozen + 1) % N4);
    end
    drain();
  endtask

  task automatic test_latency_route();
    bit          got;
    int          at;
    logic [31:0] d;
    enable4 = 1'b0;
    clear4  = 1'b1;
    step();
    clear4  = 1'b0;
    i4_req[0] = 1'b1; i4_wen[0] = 1'b1; i4_add[0] = 32'h200;
    o4_gnt  = '1;
    enable4 = 1'b1;
    #1;
    checks++;
    if (o4_req[0] !== 1'b1 || o4_add[0] !== 32'h200) begin
      failures++; $display("FAIL lat_issue out[0]: req=%b add=%h expected 1/00000200", o4_req[0], o4_add[0]);
    end
    step();
    i4_req = '0;
    got = 1'b0; at = 0; d = '0;
    for (int it = 1; it <= 6; it++) begin
      step();
      #1;
      if (!got && i4_rv[0]) begin got = 1'b1; at = it; d = i4_rd[0]; end
    end
    checks++;
    if (!got || at != 1 || d !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lat_route in[0]: seen=%b at=%0d data=%h expected 1/1/deadbeef", got, at, d);
    end
    checks++;
    if (err4 !== 1'b0) begin failures++; $display("FAIL lat_err: got %b expected 0", err4); end
  endtask

  task automatic test_orphan();
    drain();
    inj_rv = '0;
    inj_rv[3] = 1'b1;
    o4_rv[3]  = 1'b1;
    o4_rd[3]  = 32'hBAD0_0003;
    step();
    #1;
    checks++;
    if (err4 !== 1'b1) begin failures++; $display("FAIL orphan_set: got %b expected 1", err4); end
    repeat (3) step();
    clear4 = 1'b1;
    step();
    clear4 = 1'b0;
    #1;
    checks++;
    if (err4 !== 1'b0 || order4 !== 2'd0) begin
      failures++; $display("FAIL orphan_clear: err=%b order=%0d expected 0/0", err4, order4);
    end
    repeat (2) step();
  endtask

  task automatic test_nonpow2();
    int off3 = 0;
    int cnt3 = 0;
    bit bad  = 1'b0;
    enable3 = 1'b1;
    for (int c = 0; c < 100 * P3; c++) begin
      @(negedge clk);
      checks++;
      if (order3 !== 2'(off3)) begin
        failures++; bad = 1'b1;
        if (c < 8 || !bad) $display("FAIL np2_order cycle %0d: got %0d expected %0d", c, order3, off3);
      end
      if (cnt3 == P3 - 1) begin off3 = (off3 + 1) % N3; cnt3 = 0; end
      else cnt3++;
      @(posedge clk);
      #1;
    end
    enable3 = 1'b0;
    for (int i = 0; i < N3; i++) begin i3_req[i] = 1'b1; i3_add[i] = 32'h3000 + 32'(i); end
    o3_gnt = 3'b101;
    #1;
    for (int j = 0; j < N3; j++) begin
      checks++;
      if (o3_add[j] !== i3_add[(j + off3) % N3] || o3_req[j] !== 1'b1 || i3_gnt[(j + off3) % N3] !== o3_gnt[j]) begin
        failures++;
        $display("FAIL np2_map out[%0d]: add=%h expected %h", j, o3_add[j], i3_add[(j + off3) % N3]);
      end
    end
    @(posedge clk); #1;
    i3_req = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err3 !== 1'b0 || i3_rv !== '0) begin
      failures++; $display("FAIL np2_silent_drop: err=%b r_valid=%b expected 0/0", err3, i3_rv);
    end
    clear3 = 1'b1;
    @(posedge clk); #1;
    clear3 = 1'b0;
    checks++;
    if (order3 !== 2'd0) begin failures++; $display("FAIL np2_clear: got %0d expected 0", order3); end
  endtask

  initial begin
    clear4 = 1'b0; enable4 = 1'b0; clear3 = 1'b0; enable3 = 1'b0;
    i4_req = '0; i4_wen = '0; o4_gnt = '0; o4_rv = '0; inj_rv = '0;
    i3_req = '0; o3_gnt = '0;
    for (int i = 0; i < N4; i++) begin
      i4_add[i] = '0; i4_data[i] = '0; i4_be[i] = '0; o4_rd[i] = '0;
    end
    for (int i = 0; i < N3; i++) i3_add[i] = '0;
    for (int s = 0; s < L4; s++) begin
      pv[s] = '0;
      for (int j = 0; j < N4; j++) pd[s][j] = '0;
    end
    test_reset();
    test_passthrough();
    test_rotation();
    test_stall();
    test_latency_route();
    test_orphan();
    test_nonpow2();
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover: %0d responses never arrived, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
